// File: rtl/column_feeder_if.sv
// -----------------------------------------------------------------------------
// column_feeder_if
//   Bundles the two buses around column_feeder:
//   - the record channel from the ray-casting engine (valid/ready plus the
//     per-column wall fields), and
//   - the column_decoder slave write port (chipselect/write/address/writedata).
//
// Modports
//   master : the record producer. It drives col_*, sees col_ready and can
//            observe the decoder bus.
//   slave  : column_feeder itself. It accepts records and drives the
//            decoder bus.
// -----------------------------------------------------------------------------
interface column_feeder_if;
  logic        col_valid;
  logic        col_ready;
  logic        col_first;
  logic [15:0] col_start;
  logic [15:0] col_height;
  logic        col_wall_dir;
  logic [2:0]  col_tex_type;
  logic [5:0]  col_tex_col;
  logic [31:0] col_sf;

  logic        dec_chipselect;
  logic        dec_write;
  logic [3:0]  dec_address;
  logic [15:0] dec_writedata;

  modport master (
    output col_valid, col_first, col_start, col_height, col_wall_dir,
           col_tex_type, col_tex_col, col_sf,
    input  col_ready,
    input  dec_chipselect, dec_write, dec_address, dec_writedata
  );

  modport slave (
    input  col_valid, col_first, col_start, col_height, col_wall_dir,
           col_tex_type, col_tex_col, col_sf,
    output col_ready,
    output dec_chipselect, dec_write, dec_address, dec_writedata
  );
endinterface

// File: rtl/column_feeder.sv
// -----------------------------------------------------------------------------
// column_feeder
//   Buffers per-column wall records in a small FIFO and turns each one into
//   the write sequence column_decoder expects on its slave port:
//     optional address-0 write of 0 (column-number reset, frame-first only),
//     then five address-1 writes: {dir,type,col}, height, start, sf hi, sf lo.
//   One write per cycle and no bubble between columns while records are
//   queued. A 10-bit column counter flags end of frame and short frames.
//
// Ports
//   clk        : system clock
//   reset      : synchronous, active-low (0 = reset)
//   bus        : column_feeder_if.slave - record channel in, decoder bus out
//   frame_done : one-cycle pulse after the last column of a frame is written
//   frame_err  : sticky, set when a frame-first record arrives mid-frame
//   err_clr    : clears frame_err (a simultaneous set wins)
//   busy       : sequencer active or records still queued
// -----------------------------------------------------------------------------
module column_feeder #(
  parameter int DEPTH = 8,
  parameter int NCOLS = 640
) (
  input  logic             clk,
  input  logic             reset,
  column_feeder_if.slave   bus,
  output logic             frame_done,
  output logic             frame_err,
  input  logic             err_clr,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [9:0]  LAST_COL = 10'(NCOLS - 1);

  typedef struct packed {
    logic [15:0] start;
    logic [15:0] height;
    logic        wall_dir;
    logic [2:0]  tex_type;
    logic [5:0]  tex_col;
    logic [31:0] sf;
  } payload_t;

  typedef struct packed {
    logic     first;
    payload_t p;
  } rec_t;

  typedef enum logic [2:0] {IDLE, RST, S1, S2, S3, S4, S5} state_t;

  rec_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  state_t          state_q, state_d;
  payload_t        hold_q, hold_d;
  logic [9:0]      col_cnt_q, col_cnt_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_err_q, frame_err_d;
  logic            dec_cs_q, dec_cs_d;
  logic [3:0]      dec_addr_q, dec_addr_d;
  logic [15:0]     dec_data_q, dec_data_d;

  logic            full, empty, push, pop;
  rec_t            in_rec, head_rec;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  // Fullness is judged on the registered count only, so a pop in the same
  // cycle never lets a push in while full.
  assign push     = bus.col_valid && !full;
  assign head_rec = mem_q[rd_ptr_q];

  assign in_rec.first      = bus.col_first;
  assign in_rec.p.start    = bus.col_start;
  assign in_rec.p.height   = bus.col_height;
  assign in_rec.p.wall_dir = bus.col_wall_dir;
  assign in_rec.p.tex_type = bus.col_tex_type;
  assign in_rec.p.tex_col  = bus.col_tex_col;
  assign in_rec.p.sf       = bus.col_sf;

  // Record storage. Contents need no reset: the pointers and count define
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_rec;
    end
  end

  // Sequencer next state. A new record is taken from IDLE or straight out of
  // S5, which is what removes the idle bubble between columns.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: pop = !empty;
      RST:  state_d = S1;
      S1:   state_d = S2;
      S2:   state_d = S3;
      S3:   state_d = S4;
      S4:   state_d = S5;
      S5: begin
        pop     = !empty;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      hold_d  = head_rec.p;
      state_d = head_rec.first ? RST : S1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Column bookkeeping. frame_err looks at the count as it will be after this
  // edge, so a frame-first record popped right after column NCOLS-1 sees the
  // wrapped value 0 and is not flagged.
  always_comb begin
    col_cnt_d    = col_cnt_q;
    frame_done_d = 1'b0;
    if (state_q == RST) begin
      col_cnt_d = '0;
    end else if (state_q == S5) begin
      if (col_cnt_q == LAST_COL) begin
        col_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 10'd1;
      end
    end
    frame_err_d = frame_err_q;
    if (err_clr) begin
      frame_err_d = 1'b0;
    end
    if (pop && head_rec.first && (col_cnt_d != '0)) begin
      frame_err_d = 1'b1;
    end
  end

  // Decoder bus is computed from the next state and registered, so each
  // output cycle matches the state the sequencer is in.
  always_comb begin
    dec_cs_d   = 1'b0;
    dec_addr_d = 4'd0;
    dec_data_d = 16'd0;
    case (state_d)
      RST: dec_cs_d = 1'b1;
      S1: begin
        dec_cs_d   = 1'b1;
        dec_addr_d = 4'd1;
        dec_data_d = {6'b0, hold_d.wall_dir, hold_d.tex_type, hold_d.tex_col};
      end
      S2: begin
        dec_cs_d   = 1'b1;
        dec_addr_d = 4'd1;
        dec_data_d = hold_d.height;
      end
      S3: begin
        dec_cs_d   = 1'b1;
        dec_addr_d = 4'd1;
        dec_data_d = hold_d.start;
      end
      S4: begin
        dec_cs_d   = 1'b1;
        dec_addr_d = 4'd1;
        dec_data_d = hold_d.sf[31:16];
      end
      S5: begin
        dec_cs_d   = 1'b1;
        dec_addr_d = 4'd1;
        dec_data_d = hold_d.sf[15:0];
      end
      default: dec_cs_d = 1'b0;
    endcase
  end

  // State registers. Reset abandons any column in flight and drops the queue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      col_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      dec_cs_q     <= 1'b0;
      dec_addr_q   <= 4'd0;
      dec_data_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      count_q      <= count_d;
      col_cnt_q    <= col_cnt_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      dec_cs_q     <= dec_cs_d;
      dec_addr_q   <= dec_addr_d;
      dec_data_q   <= dec_data_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign bus.col_ready      = !full;
  assign bus.dec_chipselect = dec_cs_q;
  assign bus.dec_write      = dec_cs_q;
  assign bus.dec_address    = dec_addr_q;
  assign bus.dec_writedata  = dec_data_q;
  assign frame_done         = frame_done_q;
  assign frame_err          = frame_err_q;
  assign busy               = (state_q != IDLE) || !empty;

endmodule
